// File: rtl/memory_port_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory port arbiter.
package memory_port_arbiter_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_t;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/memory_lane_align.sv
// Byte-lane steering for the data path: byte enables, store replication,
// load extraction with zero-extension, and misalignment/illegal-size detection.
module memory_lane_align
    import memory_port_arbiter_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] load_word,
    output logic [3:0]        byte_enable,
    output logic [DATA_W-1:0] store_lanes,
    output logic [DATA_W-1:0] load_data,
    output logic              misaligned
);

    logic [DATA_W-1:0] load_shifted;

    always_comb begin
        byte_enable  = 4'b0000;
        store_lanes  = '0;
        misaligned   = 1'b0;
        load_shifted = load_word >> {offset, 3'b000};
        load_data    = load_shifted;
        case (size)
            MEM_SIZE_BYTE: begin
                byte_enable = 4'b0001 << offset;
                store_lanes = {4{store_data[7:0]}};
                load_data   = {24'd0, load_shifted[7:0]};
            end
            MEM_SIZE_HALF: begin
                byte_enable = offset[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{store_data[15:0]}};
                load_data   = {16'd0, load_shifted[15:0]};
                misaligned  = offset[0];
            end
            MEM_SIZE_WORD: begin
                byte_enable = 4'b1111;
                store_lanes = store_data;
                misaligned  = (offset != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one memory port between fetch and load/store: arbitrates, runs one
// transaction at a time (IDLE -> ISSUE -> WAIT) and routes the response back.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int FETCH_STARVE_LIMIT = 4
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_address,
    input  logic        fetch_flush,
    output logic        fetch_valid,
    output logic [31:0] fetch_data,
    output logic        fetch_stall,
    input  logic        data_req,
    input  logic        data_write,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_address,
    input  logic [31:0] data_wdata,
    output logic        data_valid,
    output logic [31:0] data_rdata,
    output logic        data_error,
    output logic        data_stall,
    output logic        mem_req,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int STREAK_W = $clog2(FETCH_STARVE_LIMIT + 1);
    typedef logic [STREAK_W-1:0] streak_t;
    localparam streak_t STREAK_MAX = streak_t'(FETCH_STARVE_LIMIT);

    arb_state_t state;
    owner_t     owner;
    logic       kill;
    streak_t    streak;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        lane_misaligned;
    logic        fetch_pend;
    logic        grant_fetch;
    logic        grant_data;
    logic        unused_fetch_lsbs;

    function automatic streak_t streak_sat_inc(input streak_t value);
        return (value == STREAK_MAX) ? value : value + streak_t'(1);
    endfunction

    memory_lane_align u_align (
        .size        (data_size),
        .offset      (data_address[1:0]),
        .store_data  (data_wdata),
        .load_word   (mem_rdata),
        .byte_enable (lane_be),
        .store_lanes (lane_wdata),
        .load_data   (lane_rdata),
        .misaligned  (lane_misaligned)
    );

    // Data has priority unless fetch has been passed over FETCH_STARVE_LIMIT times in a row.
    assign fetch_pend  = fetch_req & ~fetch_flush;
    assign grant_fetch = fetch_pend & (~data_req | (streak == STREAK_MAX));
    assign grant_data  = data_req & ~grant_fetch;

    assign fetch_stall       = fetch_req & ~fetch_valid;
    assign data_stall        = data_req & ~data_valid;
    assign unused_fetch_lsbs = ^fetch_address[1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            owner           <= OWNER_FETCH;
            kill            <= 1'b0;
            streak          <= '0;
            mem_req         <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= 4'b0000;
            fetch_valid     <= 1'b0;
            fetch_data      <= '0;
            data_valid      <= 1'b0;
            data_rdata      <= '0;
            data_error      <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            data_valid  <= 1'b0;
            data_error  <= 1'b0;
            case (state)
                IDLE: begin
                    kill <= 1'b0;
                    if (grant_fetch) begin
                        owner           <= OWNER_FETCH;
                        streak          <= '0;
                        mem_req         <= 1'b1;
                        mem_write       <= 1'b0;
                        mem_address     <= {fetch_address[31:2], 2'b00};
                        mem_wdata       <= '0;
                        mem_byte_enable <= 4'b1111;
                        state           <= ISSUE;
                    end else if (grant_data) begin
                        streak <= fetch_req ? streak_sat_inc(streak) : '0;
                        if (lane_misaligned) begin
                            data_valid <= 1'b1;
                            data_error <= 1'b1;
                            data_rdata <= '0;
                        end else begin
                            owner           <= OWNER_DATA;
                            mem_req         <= 1'b1;
                            mem_write       <= data_write;
                            mem_address     <= {data_address[31:2], 2'b00};
                            mem_wdata       <= data_write ? lane_wdata : '0;
                            mem_byte_enable <= lane_be;
                            state           <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (owner == OWNER_FETCH && fetch_flush) begin
                        kill <= 1'b1;
                    end
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (owner == OWNER_FETCH && fetch_flush) begin
                        kill <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        state <= IDLE;
                        kill  <= 1'b0;
                        if (owner == OWNER_FETCH) begin
                            // A flush arriving with the response still drops it.
                            if (!kill && !fetch_flush) begin
                                fetch_valid <= 1'b1;
                                fetch_data  <= mem_rdata;
                            end
                        end else begin
                            data_valid <= 1'b1;
                            data_rdata <= mem_write ? '0 : lane_rdata;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: vector table of single transactions
// plus hand-written contention, flush and reset sequences.
module tb_memory_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_req;
    logic [31:0] fetch_address;
    logic        fetch_flush;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_stall;
    logic        data_req;
    logic        data_write;
    logic [1:0]  data_size;
    logic [31:0] data_address;
    logic [31:0] data_wdata;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic        data_error;
    logic        data_stall;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    memory_port_arbiter #(.FETCH_STARVE_LIMIT(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .fetch_req       (fetch_req),
        .fetch_address   (fetch_address),
        .fetch_flush     (fetch_flush),
        .fetch_valid     (fetch_valid),
        .fetch_data      (fetch_data),
        .fetch_stall     (fetch_stall),
        .data_req        (data_req),
        .data_write      (data_write),
        .data_size       (data_size),
        .data_address    (data_address),
        .data_wdata      (data_wdata),
        .data_valid      (data_valid),
        .data_rdata      (data_rdata),
        .data_error      (data_error),
        .data_stall      (data_stall),
        .mem_req         (mem_req),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_ready       (mem_ready),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_fetch;
        logic        write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];
    vec_t v;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, "_mem_req"}, mem_req, 1'b0);
        check1({tag, "_mem_write"}, mem_write, 1'b0);
        check32({tag, "_mem_address"}, mem_address, 32'h0);
        check32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check32({tag, "_mem_be"}, {28'd0, mem_byte_enable}, 32'h0);
        check1({tag, "_fetch_valid"}, fetch_valid, 1'b0);
        check32({tag, "_fetch_data"}, fetch_data, 32'h0);
        check1({tag, "_data_valid"}, data_valid, 1'b0);
        check32({tag, "_data_rdata"}, data_rdata, 32'h0);
        check1({tag, "_data_error"}, data_error, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'h0, 32'h0000_0013, 32'h0000_1000, 4'hF, 32'h0, 32'h0000_0013, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'd0, 32'h0000_2003, 32'h0000_00AB, 32'hFFFF_FFFF, 32'h0000_2000, 4'h8, 32'hAB00_0000, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 2'd1, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 32'h0000_2000, 4'hC, 32'h0, 32'h0000_BEEF, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 2'd2, 32'h0000_2001, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 32'h0000_3001, 32'h0, 32'h1122_3344, 32'h0000_3000, 4'h2, 32'h0, 32'h0000_0033, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 2'd1, 32'h0000_3000, 32'h1234_CAFE, 32'h0, 32'h0000_3000, 4'h3, 32'h0000_CAFE, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 2'd2, 32'h0000_4008, 32'h0, 32'hDEAD_BEEF, 32'h0000_4008, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 2'd3, 32'h0000_5000, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 2'd1, 32'h0000_5001, 32'h0000_7777, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 2'd2, 32'h0000_1006, 32'h0, 32'h00A0_0093, 32'h0000_1004, 4'hF, 32'h0, 32'h00A0_0093, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'd2, 32'h0000_6004, 32'h89AB_CDEF, 32'h5A5A_5A5A, 32'h0000_6004, 4'hF, 32'h89AB_CDEF, 32'h0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 32'h0000_7003, 32'h0, 32'h80FF_0102, 32'h0000_7000, 4'h8, 32'h0, 32'h0000_0080, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 2'd1, 32'h0000_7002, 32'h0000_5566, 32'h0, 32'h0000_7000, 4'hC, 32'h5566_0000, 32'h0, 1'b0};

        reset_n       = 1'b0;
        fetch_req     = 1'b0;
        fetch_address = 32'h0;
        fetch_flush   = 1'b0;
        data_req      = 1'b0;
        data_write    = 1'b0;
        data_size     = 2'd0;
        data_address  = 32'h0;
        data_wdata    = 32'h0;
        mem_ready     = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 32'h0;

        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            v             = vecs[i];
            fetch_req     = v.is_fetch;
            fetch_address = v.addr;
            data_req      = !v.is_fetch;
            data_write    = v.write;
            data_size     = v.size;
            data_address  = v.addr;
            data_wdata    = v.wdata;
            #1;
            check1($sformatf("v%0d_stall_c0", i), v.is_fetch ? fetch_stall : data_stall, 1'b1);
            tick();
            if (v.exp_err) begin
                check1($sformatf("v%0d_err_valid", i), data_valid, 1'b1);
                check1($sformatf("v%0d_err_flag", i), data_error, 1'b1);
                check32($sformatf("v%0d_err_rdata", i), data_rdata, 32'h0);
                check1($sformatf("v%0d_err_no_mem", i), mem_req, 1'b0);
                data_req = 1'b0;
                tick();
                check1($sformatf("v%0d_err_pulse", i), data_valid, 1'b0);
                check1($sformatf("v%0d_err_idle", i), mem_req, 1'b0);
            end else begin
                check1($sformatf("v%0d_mem_req", i), mem_req, 1'b1);
                check32($sformatf("v%0d_mem_addr", i), mem_address, v.exp_addr);
                check32($sformatf("v%0d_mem_be", i), {28'd0, mem_byte_enable}, {28'd0, v.exp_be});
                check1($sformatf("v%0d_mem_write", i), mem_write, v.write);
                if (v.write) begin
                    check32($sformatf("v%0d_mem_wdata", i), mem_wdata & lane_mask(v.exp_be), v.exp_wdata);
                end
                mem_ready = 1'b1;
                tick();
                check1($sformatf("v%0d_req_drop", i), mem_req, 1'b0);
                check1($sformatf("v%0d_stall_c2", i), v.is_fetch ? fetch_stall : data_stall, 1'b1);
                mem_ready  = 1'b0;
                mem_rvalid = 1'b1;
                mem_rdata  = v.rdata;
                tick();
                mem_rvalid = 1'b0;
                if (v.is_fetch) begin
                    check1($sformatf("v%0d_fetch_valid", i), fetch_valid, 1'b1);
                    check32($sformatf("v%0d_fetch_data", i), fetch_data, v.exp_rdata);
                    check1($sformatf("v%0d_no_data_valid", i), data_valid, 1'b0);
                    check1($sformatf("v%0d_fetch_stall_c3", i), fetch_stall, 1'b0);
                end else begin
                    check1($sformatf("v%0d_data_valid", i), data_valid, 1'b1);
                    check1($sformatf("v%0d_data_error", i), data_error, 1'b0);
                    check32($sformatf("v%0d_data_rdata", i), data_rdata, v.exp_rdata);
                    check1($sformatf("v%0d_no_fetch_valid", i), fetch_valid, 1'b0);
                    check1($sformatf("v%0d_data_stall_c3", i), data_stall, 1'b0);
                end
                fetch_req = 1'b0;
                data_req  = 1'b0;
                tick();
                check1($sformatf("v%0d_valid_pulse", i), fetch_valid | data_valid, 1'b0);
                check1($sformatf("v%0d_idle", i), mem_req, 1'b0);
            end
        end

        // Contention: both requesters held; expect D,D,D,D,F then the streak restarts.
        fetch_req     = 1'b1;
        fetch_address = 32'h0000_8000;
        data_req      = 1'b1;
        data_write    = 1'b0;
        data_size     = 2'd2;
        data_address  = 32'h0000_9000;
        for (int g = 0; g < 10; g++) begin
            tick();
            check1($sformatf("cont%0d_mem_req", g), mem_req, 1'b1);
            check32($sformatf("cont%0d_grant_addr", g), mem_address,
                    (g % 5 == 4) ? 32'h0000_8000 : 32'h0000_9000);
            mem_ready = 1'b1;
            tick();
            mem_ready  = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h100 + g;
            tick();
            mem_rvalid = 1'b0;
            check1($sformatf("cont%0d_fetch_valid", g), fetch_valid, g % 5 == 4);
            check1($sformatf("cont%0d_data_valid", g), data_valid, g % 5 != 4);
            check32($sformatf("cont%0d_payload", g), (g % 5 == 4) ? fetch_data : data_rdata, 32'h100 + g);
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        tick();
        check1("cont_idle", mem_req, 1'b0);

        // Flush while the fetch waits for its response; the next fetch still issues.
        fetch_req     = 1'b1;
        fetch_address = 32'h0000_A000;
        tick();
        check32("flw_addr", mem_address, 32'h0000_A000);
        mem_ready = 1'b1;
        tick();
        mem_ready     = 1'b0;
        fetch_flush   = 1'b1;
        fetch_address = 32'h0000_B000;
        tick();
        fetch_flush = 1'b0;
        check1("flw_wait_no_req", mem_req, 1'b0);
        tick();
        check1("flw_wait_no_valid", fetch_valid, 1'b0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        tick();
        mem_rvalid = 1'b0;
        check1("flw_suppressed", fetch_valid, 1'b0);
        tick();
        check1("flw_next_req", mem_req, 1'b1);
        check32("flw_next_addr", mem_address, 32'h0000_B000);
        mem_ready = 1'b1;
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_600D;
        tick();
        mem_rvalid = 1'b0;
        check1("flw_next_valid", fetch_valid, 1'b1);
        check32("flw_next_data", fetch_data, 32'h0000_600D);
        fetch_req = 1'b0;

        // Flush in IDLE blocks the grant; flush coinciding with the response drops it.
        tick();
        fetch_req     = 1'b1;
        fetch_address = 32'h0000_C000;
        fetch_flush   = 1'b1;
        tick();
        check1("fli_blocked", mem_req, 1'b0);
        fetch_flush = 1'b0;
        tick();
        check1("fli_granted", mem_req, 1'b1);
        check32("fli_addr", mem_address, 32'h0000_C000);
        mem_ready = 1'b1;
        tick();
        mem_ready   = 1'b0;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'h1234_5678;
        fetch_flush = 1'b1;
        tick();
        mem_rvalid  = 1'b0;
        fetch_flush = 1'b0;
        fetch_req   = 1'b0;
        check1("flr_suppressed", fetch_valid, 1'b0);
        check32("flr_data_kept", fetch_data, 32'h0000_600D);

        // Reset while mem_req waits for mem_ready; the held request is re-arbitrated.
        tick();
        data_req     = 1'b1;
        data_write   = 1'b0;
        data_size    = 2'd2;
        data_address = 32'h0000_D000;
        tick();
        check1("rst_issue", mem_req, 1'b1);
        tick();
        check1("rst_held", mem_req, 1'b1);
        reset_n = 1'b0;
        tick();
        check_all_zero("midrst");
        reset_n = 1'b1;
        tick();
        check1("rst_rearb_req", mem_req, 1'b1);
        check32("rst_rearb_addr", mem_address, 32'h0000_D000);
        mem_ready = 1'b1;
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0055;
        tick();
        mem_rvalid = 1'b0;
        check1("rst_done_valid", data_valid, 1'b1);
        check32("rst_done_rdata", data_rdata, 32'h0000_0055);
        data_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
